// File: rtl/cirno_controller.sv
// Multi-cycle instruction sequencer for the Cirno core (FETCH/DECODE/EXEC/MEM/WB).
// Optional performance counters are enabled by defining CIRNO_CTRL_PERF_CNT_EN.
module cirno_controller #(
    parameter int unsigned FETCH_LAT    = 1,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] inst_type,
    input  logic       branchi,
    input  logic       branch,
    input  logic       done,
    input  logic       dmem_ready,
    output logic       init,
    output logic       ir_load,
    output logic       decoder_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_load_imm,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_wr_en,
    output logic       busy,
    output logic       halted,
    output logic       err
`ifdef CIRNO_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt
`endif
);

    localparam int unsigned CntMax = (FETCH_LAT > MEM_WAIT_MAX) ? FETCH_LAT : MEM_WAIT_MAX;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] FetchLast = CntW'(FETCH_LAT - 1);
    localparam logic [CntW-1:0] MemLast   = CntW'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic            is_store;

    assign is_store = (inst_type == 3'd5);

    // One counter serves both the fetch latency and the memory wait timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                StIdle, StHalt: begin
                    if (start) begin
                        state <= StFetch;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                StFetch: begin
                    if (cnt == FetchLast) begin
                        state <= StDecode;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StDecode: state <= StExec;
                StExec: begin
                    if (done) begin
                        state <= StHalt;
                    end else begin
                        case (inst_type)
                            3'd1, 3'd4: state <= StWb;
                            3'd2, 3'd3: state <= StFetch;
                            3'd5, 3'd6: begin
                                state <= StMem;
                                cnt   <= '0;
                            end
                            default: begin
                                state <= StHalt;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                StMem: begin
                    if (dmem_ready) begin
                        state <= is_store ? StFetch : StWb;
                        cnt   <= '0;
                    end else if (cnt == MemLast) begin
                        state <= StHalt;
                        err   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StWb:    state <= StFetch;
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        init        = 1'b0;
        ir_load     = 1'b0;
        decoder_en  = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_wr_en   = 1'b0;
        busy        = (state != StIdle) && (state != StHalt);
        halted      = (state == StHalt);
        case (state)
            StIdle, StHalt: init = start;
            StFetch:        ir_load = (cnt == FetchLast);
            StDecode:       decoder_en = 1'b1;
            StExec: begin
                // A halt instruction leaves the PC untouched.
                if (!done) begin
                    if (inst_type == 3'd2) begin
                        pc_load_imm = branchi;
                        pc_inc      = !branchi;
                    end else if (inst_type == 3'd3) begin
                        pc_load = branch;
                        pc_inc  = !branch;
                    end
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_inc   = dmem_ready && is_store;
            end
            StWb: begin
                reg_wr_en = 1'b1;
                pc_inc    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CIRNO_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (init) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            if (busy) cycle_cnt <= cycle_cnt + 32'd1;
            if (state == StDecode) inst_cnt <= inst_cnt + 32'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_cirno_controller.sv
// Randomized instruction-stream bench for cirno_controller; expected strobes come from
// a per-instruction timeline model built from the instruction-class rules.
module tb_cirno_controller;

    localparam int unsigned FL = 1;
    localparam int unsigned MW = 15;

    localparam logic [11:0] INIT = 12'h800, IRL = 12'h400, DEC = 12'h200, PINC = 12'h100;
    localparam logic [11:0] PLD = 12'h080, PIMM = 12'h040, REQ = 12'h020, WE = 12'h010;
    localparam logic [11:0] RWE = 12'h008, BUSY = 12'h004, HLT = 12'h002, ERR = 12'h001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] inst_type = 3'd0;
    logic       branchi = 1'b0, branch = 1'b0, done = 1'b0, dmem_ready = 1'b0;
    logic       init, ir_load, decoder_en, pc_inc, pc_load, pc_load_imm;
    logic       dmem_req, dmem_we, reg_wr_en, busy, halted, err;
`ifdef CIRNO_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, inst_cnt;
`endif
    logic [11:0] obs;

    int   vectors = 0;
    int   miscompares = 0;
    logic err_m = 1'b0;
    logic halted_m = 1'b0;
    int   cyc_m = 0;
    int   inst_m = 0;

    cirno_controller #(.FETCH_LAT(FL), .MEM_WAIT_MAX(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_type(inst_type),
        .branchi(branchi), .branch(branch), .done(done), .dmem_ready(dmem_ready),
        .init(init), .ir_load(ir_load), .decoder_en(decoder_en), .pc_inc(pc_inc),
        .pc_load(pc_load), .pc_load_imm(pc_load_imm), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_wr_en(reg_wr_en), .busy(busy), .halted(halted),
        .err(err)
`ifdef CIRNO_CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {init, ir_load, decoder_en, pc_inc, pc_load, pc_load_imm,
                  dmem_req, dmem_we, reg_wr_en, busy, halted, err};

    // Inputs the controller must ignore in the current cycle get random values.
    task automatic junk();
        inst_type  = 3'($urandom);
        branch     = 1'($urandom);
        branchi    = 1'($urandom);
        done       = 1'($urandom);
        dmem_ready = 1'($urandom);
        start      = 1'($urandom);
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, returns at next posedge+1.
    task automatic cyc(input logic [11:0] exp_in, input string tag);
        logic [11:0] exp;
        exp = exp_in | (err_m ? ERR : 12'h000);
        #4;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        if ((exp_in & BUSY) != 12'h000) cyc_m++;
        if ((exp_in & DEC) != 12'h000) inst_m++;
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b1;
        cyc(INIT | (halted_m ? HLT : 12'h000), "init");
        start    = 1'b0;
        err_m    = 1'b0;
        halted_m = 1'b0;
        cyc_m    = 0;
        inst_m   = 0;
    endtask

    task automatic check_halt();
        start = 1'b0;
        cyc(HLT, "halt");
`ifdef CIRNO_CTRL_PERF_CNT_EN
        vectors++;
        assert (cycle_cnt === 32'(cyc_m) && inst_cnt === 32'(inst_m)) else begin
            miscompares++;
            $error("FAIL perf_cnt: observed %0d/%0d expected %0d/%0d",
                   cycle_cnt, inst_cnt, cyc_m, inst_m);
        end
`endif
    endtask

    // rdy = MEM cycle on which dmem_ready rises (1..MW), 0 = never.
    task automatic run_inst(input logic [2:0] t, input logic flag, input logic dn, input int rdy);
        logic [11:0] exp;
        for (int i = 0; i < int'(FL); i++) begin
            junk();
            cyc(BUSY | ((i == int'(FL) - 1) ? IRL : 12'h000), "fetch");
        end
        junk();
        cyc(BUSY | DEC, "decode");
        junk();
        inst_type = t;
        done      = dn;
        if (t == 3'd3) branch = flag;
        else branchi = flag;
        if (dn) begin
            cyc(BUSY, "exec_done");
            halted_m = 1'b1;
            return;
        end
        case (t)
            3'd1, 3'd4: begin
                cyc(BUSY, "exec_alu");
                junk();
                cyc(BUSY | RWE | PINC, "wb_alu");
            end
            3'd2: cyc(BUSY | (flag ? PIMM : PINC), "exec_branchi");
            3'd3: cyc(BUSY | (flag ? PLD : PINC), "exec_branch");
            3'd5, 3'd6: begin
                cyc(BUSY, "exec_mem");
                for (int k = 1; k <= int'(MW); k++) begin
                    junk();
                    start      = 1'b0;
                    inst_type  = t;
                    dmem_ready = (k == rdy);
                    exp = BUSY | REQ | ((t == 3'd5) ? WE : 12'h000);
                    if (k == rdy && t == 3'd5) exp = exp | PINC;
                    cyc(exp, "mem");
                    if (k == rdy) break;
                end
                if (rdy >= 1 && rdy <= int'(MW)) begin
                    if (t == 3'd6) begin
                        junk();
                        cyc(BUSY | RWE | PINC, "wb_load");
                    end
                end else begin
                    err_m    = 1'b1;
                    halted_m = 1'b1;
                end
            end
            default: begin
                cyc(BUSY, "exec_illegal");
                err_m    = 1'b1;
                halted_m = 1'b1;
            end
        endcase
    endtask

    initial begin
        int r;
        logic [2:0] t;
        repeat (2) @(posedge clk);
        #1;
        cyc(12'h000, "in_reset");
        rst_n = 1'b1;
        cyc(12'h000, "idle");
        cyc(12'h000, "idle_hold");

        launch();
        run_inst(3'd1, 1'b0, 1'b0, 0);
        run_inst(3'd6, 1'b0, 1'b0, 3);
        run_inst(3'd5, 1'b0, 1'b0, 3);
        run_inst(3'd5, 1'b0, 1'b0, 1);
        run_inst(3'd6, 1'b0, 1'b0, int'(MW));
        run_inst(3'd4, 1'b0, 1'b0, 0);
        run_inst(3'd2, 1'b1, 1'b0, 0);
        run_inst(3'd2, 1'b0, 1'b0, 0);
        run_inst(3'd3, 1'b0, 1'b0, 0);
        run_inst(3'd3, 1'b1, 1'b0, 0);
        run_inst(3'd1, 1'b0, 1'b1, 0);
        check_halt();
        check_halt();

        launch();
        run_inst(3'd7, 1'b0, 1'b0, 0);
        check_halt();
        launch();
        run_inst(3'd1, 1'b0, 1'b0, 0);
        run_inst(3'd6, 1'b0, 1'b0, 0);
        check_halt();
        launch();
        run_inst(3'd0, 1'b0, 1'b0, 0);
        check_halt();
        launch();

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 15));
            t = (r < 14) ? 3'(1 + r % 6) : ((r == 14) ? 3'd0 : 3'd7);
            run_inst(t, 1'($urandom), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, MW)));
            if (halted_m) begin
                check_halt();
                launch();
            end
        end

        // Asynchronous reset while a load is waiting in MEM.
        run_inst(3'd1, 1'b0, 1'b0, 0);
        junk();
        cyc(BUSY | IRL, "fetch_pre_rst");
        junk();
        cyc(BUSY | DEC, "decode_pre_rst");
        junk();
        inst_type = 3'd6;
        done      = 1'b0;
        cyc(BUSY, "exec_pre_rst");
        start      = 1'b0;
        inst_type  = 3'd6;
        dmem_ready = 1'b0;
        cyc(BUSY | REQ, "mem_pre_rst");
        start = 1'b0;
        #1 rst_n = 1'b0;
        err_m    = 1'b0;
        halted_m = 1'b0;
        cyc(12'h000, "rst_mid_mem");
        rst_n = 1'b1;
        cyc(12'h000, "idle_after_rst");
        launch();
        run_inst(3'd1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
